// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- hazard and stall/flush controller for the 5-stage pipeline.
//
// Detects load-use hazards (ID vs. load in EX), control redirects from EX and
// data-memory freezes in MEM, and drives the PC / pipeline-register enables and
// bubble-flush controls. A data-memory access that stays unacknowledged for
// TIMEOUT freeze cycles halts the core until reset.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1, id_rs2                source registers of the ID instruction
//   id_rs1_used, id_rs2_used      ID instruction really reads rs1 / rs2
//   ex_rd, ex_memread             destination / is-load of the EX instruction
//   ex_npc_op                     next-PC op of EX (nonzero = redirect)
//   mem_req, mem_ack              data-memory handshake of the MEM instruction
//   pc_en .. ex_mem_en            load enables
//   if_id_flush .. mem_wb_flush   load a bubble this cycle
//   pc_redirect                   PC takes the EX-computed target
//   halted                        core halted after a memory timeout
//   stall_cnt, flush_cnt          saturating performance counters
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic [2:0]       ex_npc_op,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             pc_redirect,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    logic freeze, redir, lu, rs1_hit, rs2_hit;

    // HALT keeps the whole pipe frozen regardless of the memory handshake.
    assign freeze  = (state == HALT) | (mem_req & ~mem_ack);
    // A redirect in EX cannot leave while EX is frozen; it is taken on release.
    assign redir   = (ex_npc_op != 3'b000) & ~freeze;
    assign rs1_hit = id_rs1_used & (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_used & (id_rs2 == ex_rd);
    // x0 is never a real dependency.
    assign lu      = ex_memread & (ex_rd != 5'd0) & (rs1_hit | rs2_hit) & ~freeze & ~redir;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        pc_redirect  = 1'b0;
        if (rst) begin
            // Flush everything so the pipe comes out of reset full of bubbles.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (redir) begin
            pc_redirect  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (lu) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    // Ack in the last allowed cycle still beats the timeout.
                    if (mem_ack) begin
                        state <= RUN;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase

            if (!pc_en && state != HALT && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (pc_redirect && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_memread, mem_req, mem_ack;
    logic [2:0] ex_npc_op;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic       if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect, halted;
    logic [3:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect}
    logic [7:0] ctl;
    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                  if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect};

    localparam logic [7:0] C_IDLE   = 8'b1111_0000;
    localparam logic [7:0] C_FREEZE = 8'b0000_0010;
    localparam logic [7:0] C_REDIR  = 8'b1111_1101;
    localparam logic [7:0] C_LU     = 8'b0011_0100;
    localparam logic [7:0] C_RST    = 8'b1111_1110;

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_npc_op(ex_npc_op),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
        .pc_redirect(pc_redirect), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change 1 time unit after it, outputs sampled 2 after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = 5'd0; ex_memread = 1'b0; ex_npc_op = 3'b000;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_memread = 1'b1; ex_rd = rd; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        set_load_use(5'd5);
        mem_req = 1'b1;
        #1;
        checks++; if (ctl !== C_RST) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST); end
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
        checks++; if (flush_cnt !== 4'd0) begin failures++; $display("FAIL reset_flush got=%0d exp=0", flush_cnt); end
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL reset_idle got=%b exp=%b", ctl, C_IDLE); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5'd5);
        #1;
        checks++; if (ctl !== C_LU) begin failures++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, C_LU); end
        step();
        ex_memread = 1'b0;   // bubble now in EX
        #1;
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL lu_clear got=%b exp=%b", ctl, C_IDLE); end
        checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        // x0 destination: no hazard
        set_load_use(5'd0); id_rs1 = 5'd0;
        #1;
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL lu_x0 got=%b exp=%b", ctl, C_IDLE); end
        // rs1 matches but is not read
        set_load_use(5'd5); id_rs1_used = 1'b0;
        #1;
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL lu_unused got=%b exp=%b", ctl, C_IDLE); end
        // rs2 match
        id_rs2 = 5'd5; id_rs2_used = 1'b1;
        #1;
        checks++; if (ctl !== C_LU) begin failures++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU); end
        step();
        idle_inputs();
        #1;
        checks++; if (stall_cnt !== 4'd2) begin failures++; $display("FAIL lu_stall_cnt2 got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_redirect();
        do_reset();
        set_load_use(5'd5);
        ex_npc_op = 3'b100;
        #1;
        checks++; if (ctl !== C_REDIR) begin failures++; $display("FAIL redir_over_lu got=%b exp=%b", ctl, C_REDIR); end
        step();
        idle_inputs();
        ex_npc_op = 3'b011;  // illegal multi-hot still redirects
        #1;
        checks++; if (ctl !== C_REDIR) begin failures++; $display("FAIL redir_multihot got=%b exp=%b", ctl, C_REDIR); end
        checks++; if (flush_cnt !== 4'd1) begin failures++; $display("FAIL redir_flush_cnt got=%0d exp=1", flush_cnt); end
        checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL redir_stall_cnt got=%0d exp=0", stall_cnt); end
        step();
        idle_inputs();
        #1;
        checks++; if (flush_cnt !== 4'd2) begin failures++; $display("FAIL redir_flush_cnt2 got=%0d exp=2", flush_cnt); end
    endtask

    task automatic test_mem_freeze();
        do_reset();
        mem_req = 1'b1;
        ex_npc_op = 3'b001;  // pending taken branch, held while frozen
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== C_FREEZE) begin failures++; $display("FAIL freeze_cyc%0d got=%b exp=%b", i, ctl, C_FREEZE); end
            step();
        end
        mem_ack = 1'b1;
        set_load_use(5'd5);  // redirect still wins on release
        #1;
        checks++; if (ctl !== C_REDIR) begin failures++; $display("FAIL freeze_release got=%b exp=%b", ctl, C_REDIR); end
        step();
        idle_inputs();
        #1;
        checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL freeze_stall_cnt got=%0d exp=3", stall_cnt); end
        checks++; if (flush_cnt !== 4'd1) begin failures++; $display("FAIL freeze_flush_cnt got=%0d exp=1", flush_cnt); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL freeze_halted got=%b exp=0", halted); end
        // back to RUN: req+ack together is no freeze; then load-use directly after
        mem_req = 1'b1; mem_ack = 1'b1;
        #1;
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL reqack_same got=%b exp=%b", ctl, C_IDLE); end
        step();
        idle_inputs();
        set_load_use(5'd5);
        #1;
        checks++; if (ctl !== C_LU) begin failures++; $display("FAIL b2b_lu got=%b exp=%b", ctl, C_LU); end
        step();
        idle_inputs();
        #1;
        checks++; if (stall_cnt !== 4'd4) begin failures++; $display("FAIL b2b_stall_cnt got=%0d exp=4", stall_cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (ctl !== C_FREEZE || halted !== 1'b0) begin
                failures++; $display("FAIL timeout_cyc%0d ctl=%b halted=%b exp ctl=%b halted=0", i, ctl, halted, C_FREEZE);
            end
            step();
        end
        mem_req = 1'b0; mem_ack = 1'b1;  // late ack is ignored in HALT
        #1;
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL timeout_halted got=%b exp=1", halted); end
        checks++; if (ctl !== C_FREEZE) begin failures++; $display("FAIL halt_ctl got=%b exp=%b", ctl, C_FREEZE); end
        checks++; if (stall_cnt !== 4'd4) begin failures++; $display("FAIL timeout_stall_cnt got=%0d exp=4", stall_cnt); end
        step(); step(); step();
        #1;
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%b exp=1", halted); end
        checks++; if (stall_cnt !== 4'd4) begin failures++; $display("FAIL halt_no_count got=%0d exp=4", stall_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (ctl !== C_RST) begin failures++; $display("FAIL halt_rst_ctl got=%b exp=%b", ctl, C_RST); end
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_rst_halted got=%b exp=0", halted); end
        checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL halt_rst_run got=%b exp=%b", ctl, C_IDLE); end
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_use(5'd5);  // continuous stall
        for (int i = 0; i < 14; i++) step();
        #1;
        checks++; if (stall_cnt !== 4'd14) begin failures++; $display("FAIL sat_14 got=%0d exp=14", stall_cnt); end
        for (int i = 0; i < 6; i++) step();
        #1;
        checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_freeze();
        test_timeout();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
